// File: rtl/hex_display_scan_pkg.sv
// Shared types, default parameters and the leading-zero helper for the hex
// display scan path.
//   nibble_t        : one hex digit as presented to the segment decoder
//   DEFAULT_NDIGITS : digits scanned when the parent does not override
//   DEFAULT_DIV     : clock cycles per digit slot when not overridden
//   lz_mask()       : per-digit blank vector for a 32-bit display word
package hexdisp_pkg;

    typedef logic [3:0] nibble_t;

    localparam int DEFAULT_NDIGITS = 8;
    localparam int DEFAULT_DIV     = 50000;

    // Bit i is set when digit i and every digit above it (up to ndig-1) are
    // zero. Digit 0 is never flagged, so a zero word still shows one '0'.
    function automatic logic [7:0] lz_mask(input logic [31:0] word, input int ndig);
        logic [7:0] m;
        logic       zero_above;
        m          = 8'h00;
        zero_above = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < ndig) begin
                zero_above = zero_above & (word[4*i +: 4] == 4'h0);
                m[i]       = zero_above & (i != 0);
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// Value handshake between the producer of the word to display and the scan
// controller.
//   val_in    : 32-bit word, nibble i in bits [4i+3:4i]
//   val_valid : producer has a word this cycle
//   val_ready : consumer can take a word (transfer on valid && ready)
interface hex_display_scan_if;
    logic [31:0] val_in;
    logic        val_valid;
    logic        val_ready;

    modport master (output val_in, output val_valid, input val_ready);
    modport slave  (input val_in, input val_valid, output val_ready);
endinterface

// File: rtl/hex_display_scan_tick_div.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
//   clk  : system clock
//   rst  : synchronous active-high reset (count restarts at 0)
//   tick : high on the last cycle of each DIV-cycle period
module tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(DIV - 1);
    localparam logic [PC_W-1:0] PC_ZERO = PC_W'(0);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    logic [PC_W-1:0] pc_r;

    assign tick = (pc_r == PC_LAST);

    // Count 0..DIV-1, wrapping by explicit compare rather than rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= PC_ZERO;
        end else if (tick) begin
            pc_r <= PC_ZERO;
        end else begin
            pc_r <= pc_r + PC_ONE;
        end
    end

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed hex display scan controller with a one-deep pending buffer.
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : value handshake (slave side)
//   nibble     : hex digit for the currently selected position
//   blank      : current digit is a leading zero and must be dark
//   dig_sel_n  : one-hot active-low digit enable, all ones during dead cycle
//   frame_done : pulse on the last cycle of each frame
module hex_display_scan
    import hexdisp_pkg::*;
#(
    parameter int NDIGITS  = DEFAULT_NDIGITS,
    parameter int DIV      = DEFAULT_DIV,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    hex_display_scan_if.slave   bus,
    output nibble_t             nibble,
    output logic                blank,
    output logic [NDIGITS-1:0]  dig_sel_n,
    output logic                frame_done
);

    localparam int              DC_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(NDIGITS - 1);
    localparam logic [DC_W-1:0] DC_ZERO = DC_W'(0);
    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

    logic            tick_s;
    logic            boundary_s;
    logic            xfer_s;
    logic [7:0]      lz_s;
    logic [DC_W-1:0] dc_r;
    logic [31:0]     disp_r;
    logic [31:0]     pend_r;
    logic            pend_full_r;
    // Mirrors "prescaler == 0": set on reset and on the edge after each tick.
    logic            dead_r;

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    assign boundary_s    = tick_s && (dc_r == DC_LAST);
    assign xfer_s        = bus.val_valid && !pend_full_r;
    assign bus.val_ready = !pend_full_r;
    assign frame_done    = boundary_s;
    assign lz_s          = lz_mask(disp_r, NDIGITS);

    // Digit counter, display/pending buffers and the dead-cycle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dc_r        <= DC_ZERO;
            disp_r      <= 32'h0000_0000;
            pend_r      <= 32'h0000_0000;
            pend_full_r <= 1'b0;
            dead_r      <= 1'b1;
        end else begin
            dead_r <= tick_s;
            if (tick_s) begin
                dc_r <= (dc_r == DC_LAST) ? DC_ZERO : (dc_r + DC_ONE);
            end else begin
                dc_r <= dc_r;
            end
            // Drain needs pend_full, accept needs !pend_full: never both.
            if (boundary_s && pend_full_r) begin
                disp_r      <= pend_r;
                pend_full_r <= 1'b0;
            end else if (xfer_s) begin
                pend_r      <= bus.val_in;
                pend_full_r <= 1'b1;
            end else begin
                pend_r      <= pend_r;
                pend_full_r <= pend_full_r;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        nibble    = disp_r[{dc_r, 2'b00} +: 4];
        blank     = (BLANK_LZ != 0) && lz_s[dc_r];
        dig_sel_n = '1;
        if (!dead_r) begin
            dig_sel_n[dc_r] = 1'b0;
        end else begin
            dig_sel_n = '1;
        end
    end

endmodule
